cordic_rotacao_iterativa: RTL and testbench
===========================================

// Module: cordic_rotacao_iterativa
// PURPOSE
//  Iterative rotation-mode CORDIC core directly downstream of the quadrant-correction stage.
//  It consumes the corrected angle z_in and the sign flags sinal_seno / sinal_cosseno.
//  It runs ITERATIONS micro-rotations, one per clock, and returns registered seno/cosseno.
//  The quadrant sign correction is already applied. Start/done handshake, one operation in flight.
// PARAMETERS
//  ITERATIONS  16  micro-rotations per operation (1..WIDTH-2)
//  WIDTH       32  data width; angles are Q16.16 degrees (90 deg = 5898240), sin/cos are Q16.16 (1.0 = 65536)
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  start          in   1      request; sampled only in IDLE
//  z_in           in   WIDTH  signed corrected angle, within [-5898240, +5898240]
//  sinal_seno     in   2      signed +1/-1 factor for the sine result
//  sinal_cosseno  in   2      signed +1/-1 factor for the cosine result
//  busy           out  1      high in CALC and OUT
//  done           out  1      one-cycle pulse; seno/cosseno valid from this cycle on
//  seno           out  WIDTH  signed sine, Q16.16
//  cosseno        out  WIDTH  signed cosine, Q16.16
// BEHAVIOUR
//  - Reset, async: FSM=IDLE; x, y, z, i = 0; seno=0, cosseno=0; busy=0, done=0; sign regs = +1.
//  - FSM states: IDLE -> CALC -> OUT -> IDLE.
//  - IDLE with start=1 (edge T0):
//    - load x=K_GAIN (39797), y=0, z=z_in, i=0;
//    - capture sinal_seno and sinal_cosseno into internal regs;
//    - go to CALC.
//  - CALC, one micro-rotation per cycle, d = (z>=0):
//    - d=1: x-=y>>>i, y+=x>>>i, z-=ATAN[i]
//    - d=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i]
//    - Old x/y values are used on both right-hand sides. Shifts are arithmetic. i increments each cycle.
//    - After the step with i==ITERATIONS-1, go to OUT.
//  - OUT: register the results and pulse done=1 for one cycle, then go to IDLE.
//    - seno = sign_s[1] ? -y : y
//    - cosseno = sign_c[1] ? -x : x
//    - Only the sign bit of each flag matters.
//  - Latency: done is high in the cycle after edge T0+ITERATIONS+1, so start->done = ITERATIONS+2 clocks.
//    Back-to-back throughput is one result per ITERATIONS+2 clocks.
//  - start while busy: ignored; no queueing. start held high in IDLE launches a new operation every pass.
//  - seno/cosseno hold their last value until the next OUT; no change in IDLE or CALC.
//  - z_in/sign inputs: sampled only on the accepting edge; later changes have no effect.
//  - Arithmetic: all WIDTH-bit two's complement.
//    - |x|,|y| <= 1.65*65536, so no overflow at WIDTH=32.
//    - Residual z is discarded.
//  - rst asserted mid-operation: abort immediately to reset values; no done pulse. The first start after release is a fresh operation.
// STRUCTURE
//  - Package cordic_pkg holds the shared constants:
//    - ATAN table, Q16.16 deg: 2949120, 1740967, 919879, 466945, ... to entry 15;
//    - K_GAIN = 39797;
//    - ANG_90 = 5898240 and ANG_180 = 11796480, shared with the quadrant stage;
//    - state encoding IDLE/CALC/OUT.
//  - Sub-module cordic_atan_rom: combinational index -> ATAN[i], WIDTH out, entries beyond 15 = 0.
//  - Core holds the FSM, iteration counter, x/y/z datapath with variable arithmetic shifters, and the output sign stage.
// TESTING  (tolerance +/-16 LSB on seno/cosseno)
//  1. z_in=0, signs +1/+1, start 1 cycle -> done at start+18 clocks; seno~0, cosseno~65536.
//  2. z_in=1966080 (30 deg), +1/+1 -> seno~32768, cosseno~56756.
//     Then z_in=-1966080 -> seno~-32768, cosseno~56756.
//  3. z_in=5898240 (90 deg) -> seno~65536, cosseno~0.
//     Then z_in=1966080 with sinal_cosseno=-1 (150 deg) -> seno~32768, cosseno~-56756.
//  4. start pulsed at cycles 3 and 9 of a running op -> exactly one done; results match the first operand.
//     z_in changed mid-op -> no effect.
//  5. rst asserted at CALC iteration 7 -> outputs 0, busy=0, no done.
//     start after release with 45 deg (2949120) -> seno~cosseno~46341.
//  6. start held high for 3 operations -> done pulses exactly 18 clocks apart; busy low for exactly one IDLE cycle between them.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, gain, quadrant angles
// and the iterative core's state encoding.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int K_GAIN   = 39797;
    localparam int ANG_90   = 5898240;
    localparam int ANG_180  = 11796480;
    localparam int ATAN_LEN = 16;

    // atan(2^-idx) in Q16.16 degrees; zero past the table end
    function automatic int atan_q16(input int idx);
        case (idx)
            0:       return 2949120;
            1:       return 1740967;
            2:       return 919879;
            3:       return 466945;
            4:       return 234379;
            5:       return 117304;
            6:       return 58666;
            7:       return 29335;
            8:       return 14668;
            9:       return 7334;
            10:      return 3667;
            11:      return 1833;
            12:      return 917;
            13:      return 458;
            14:      return 229;
            15:      return 115;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_rotacao_iterativa_if.sv
// Start/done handshake and operand/result bundle between the
// quadrant-correction stage and the iterative CORDIC core.
interface cordic_rotacao_iterativa_if #(
    parameter int WIDTH = 32
);
    logic                    start;
    logic signed [WIDTH-1:0] z_in;
    logic [1:0]              sinal_seno;
    logic [1:0]              sinal_cosseno;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] seno;
    logic signed [WIDTH-1:0] cosseno;

    modport master (
        output start, z_in, sinal_seno, sinal_cosseno,
        input  busy, done, seno, cosseno
    );

    modport slave (
        input  start, z_in, sinal_seno, sinal_cosseno,
        output busy, done, seno, cosseno
    );
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup for the micro-rotation index.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IW    = 5
) (
    input  logic [IW-1:0]           idx,
    output logic signed [WIDTH-1:0] atan
);
    always_comb begin
        atan = WIDTH'(atan_q16(int'(idx)));
    end
endmodule

// File: rtl/cordic_rotacao_iterativa.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock,
// quadrant sign applied when the result is registered.
module cordic_rotacao_iterativa
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 16,
    parameter int WIDTH      = 32
) (
    input logic clk,
    input logic rst,
    cordic_rotacao_iterativa_if.slave bus
);
    localparam int IW = $clog2(WIDTH);

    state_t                  state;
    state_t                  state_nx;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] z;
    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;
    logic signed [WIDTH-1:0] atan;
    logic [IW-1:0]           i;
    logic                    sign_s;
    logic                    sign_c;
    logic                    last_step;

    cordic_atan_rom #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_rom (
        .idx  (i),
        .atan (atan)
    );

    assign x_sh      = x >>> i;
    assign y_sh      = y >>> i;
    assign last_step = (i == IW'(ITERATIONS - 1));
    assign bus.busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = CALC;
            CALC:    if (last_step) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Both updates read the pre-step x/y, so the rotation stays exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            z           <= '0;
            i           <= '0;
            sign_s      <= 1'b0;
            sign_c      <= 1'b0;
            bus.done    <= 1'b0;
            bus.seno    <= '0;
            bus.cosseno <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        x      <= WIDTH'(K_GAIN);
                        y      <= '0;
                        z      <= bus.z_in;
                        i      <= '0;
                        sign_s <= bus.sinal_seno[1];
                        sign_c <= bus.sinal_cosseno[1];
                    end
                end
                CALC: begin
                    if (!z[WIDTH-1]) begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan;
                    end else begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan;
                    end
                    i <= i + IW'(1);
                end
                OUT: begin
                    bus.seno    <= sign_s ? -y : y;
                    bus.cosseno <= sign_c ? -x : x;
                    bus.done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_rotacao_iterativa.sv
// Randomised self-checking bench for the iterative CORDIC core,
// checked against a floating-point sine/cosine model.
module tb_cordic_rotacao_iterativa;
    localparam int    WIDTH = 32;
    localparam int    ITER  = 16;
    localparam int    LAT   = ITER + 2;
    localparam int    TOL   = 16;
    localparam int    A90   = 5898240;
    localparam real   PI    = 3.14159265358979323846;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   last_es;
    int   last_ec;

    cordic_rotacao_iterativa_if #(.WIDTH(WIDTH)) bus ();

    cordic_rotacao_iterativa #(
        .ITERATIONS (ITER),
        .WIDTH      (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_val(input int z, input logic [1:0] f,
                                   input bit is_sin);
        real a;
        real v;
        a = real'(z) / 65536.0 * PI / 180.0;
        v = is_sin ? $sin(a) : $cos(a);
        v = v * 65536.0;
        if (f[1]) v = -v;
        return int'(v);
    endfunction

    function automatic bit near(input int act, input int exp_v);
        int d;
        d = act - exp_v;
        return (d <= TOL) && (d >= -TOL);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch with start held one edge; count edges (accepting edge = 1)
    // until done is seen.
    task automatic run_op(input int z, input logic [1:0] ss,
                          input logic [1:0] sc, output int lat,
                          output int s, output int c);
        bus.start = 1'b1;
        bus.z_in = z;
        bus.sinal_seno = ss;
        bus.sinal_cosseno = sc;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 1) begin
                bus.start = 1'b0;
                bus.z_in = $urandom;
                bus.sinal_seno = 2'($urandom);
                bus.sinal_cosseno = 2'($urandom);
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        s = bus.seno;
        c = bus.cosseno;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.z_in = '0;
        bus.sinal_seno = 2'b01;
        bus.sinal_cosseno = 2'b01;
        tick();
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got %b want 0", bus.done);
        end
        n_checks++;
        if (bus.seno !== 0 || bus.cosseno !== 0) begin
            n_fail++;
            $display("FAIL reset_out got %0d/%0d want 0/0",
                     bus.seno, bus.cosseno);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_angle(input string name, input int z,
                              input logic [1:0] ss, input logic [1:0] sc,
                              input bit chk_lat);
        int lat, s, c, es, ec;
        es = ref_val(z, ss, 1'b1);
        ec = ref_val(z, sc, 1'b0);
        run_op(z, ss, sc, lat, s, c);
        if (chk_lat) begin
            n_checks++;
            if (lat !== LAT) begin
                n_fail++;
                $display("FAIL %s_latency got %0d want %0d", name, lat, LAT);
            end
        end
        n_checks++;
        if (lat == 0 || !near(s, es)) begin
            n_fail++;
            $display("FAIL %s_seno got %0d want %0d", name, s, es);
        end
        n_checks++;
        if (lat == 0 || !near(c, ec)) begin
            n_fail++;
            $display("FAIL %s_cosseno got %0d want %0d", name, c, ec);
        end
        last_es = es;
        last_ec = ec;
    endtask

    task automatic test_known_angles();
        test_angle("zero", 0, 2'b01, 2'b01, 1'b1);
        test_angle("p30", 1966080, 2'b01, 2'b01, 1'b0);
        test_angle("m30", -1966080, 2'b01, 2'b01, 1'b0);
        test_angle("p90", A90, 2'b01, 2'b01, 1'b0);
        test_angle("q150", 1966080, 2'b01, 2'b11, 1'b0);
        test_angle("m90_neg", -A90, 2'b11, 2'b11, 1'b0);
    endtask

    task automatic test_random();
        int z;
        for (int n = 0; n < 10; n++) begin
            z = int'($urandom_range(2 * A90)) - A90;
            test_angle("rand", z, 2'($urandom), 2'($urandom), n == 0);
        end
    endtask

    // Stray starts and operand changes while busy must not disturb the op.
    task automatic test_busy_ignore();
        int z, es, ec, dones, lat;
        z = int'($urandom_range(2 * A90)) - A90;
        es = ref_val(z, 2'b01, 1'b1);
        ec = ref_val(z, 2'b11, 1'b0);
        dones = 0;
        lat = 0;
        bus.start = 1'b1;
        bus.z_in = z;
        bus.sinal_seno = 2'b01;
        bus.sinal_cosseno = 2'b11;
        for (int k = 1; k <= 45; k++) begin
            tick();
            bus.start = (k == 3 || k == 9);
            if (k == 5) begin
                bus.z_in = -z;
                bus.sinal_seno = 2'b11;
                bus.sinal_cosseno = 2'b01;
            end
            if (k == 10) begin
                n_checks++;
                if (!near(bus.seno, last_es) || !near(bus.cosseno, last_ec)) begin
                    n_fail++;
                    $display("FAIL hold_in_calc got %0d/%0d want %0d/%0d",
                             bus.seno, bus.cosseno, last_es, last_ec);
                end
            end
            if (bus.done) begin
                dones++;
                if (lat == 0) lat = k;
                n_checks++;
                if (!near(bus.seno, es) || !near(bus.cosseno, ec)) begin
                    n_fail++;
                    $display("FAIL busy_result got %0d/%0d want %0d/%0d",
                             bus.seno, bus.cosseno, es, ec);
                end
            end
        end
        n_checks++;
        if (dones !== 1 || lat !== LAT) begin
            n_fail++;
            $display("FAIL busy_single_done got %0d pulses lat %0d want 1 lat %0d",
                     dones, lat, LAT);
        end
        last_es = es;
        last_ec = ec;
    endtask

    task automatic test_reset_mid();
        int dones;
        bus.start = 1'b1;
        bus.z_in = 1966080;
        bus.sinal_seno = 2'b01;
        bus.sinal_cosseno = 2'b01;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.seno !== 0 || bus.cosseno !== 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_out got %0d/%0d busy %b want 0/0 busy 0",
                     bus.seno, bus.cosseno, bus.busy);
        end
        tick();
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.done || bus.busy) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet got %0d active cycles want 0", dones);
        end
        test_angle("post_rst45", 2949120, 2'b01, 2'b01, 1'b1);
    endtask

    task automatic test_back_to_back();
        int z, es, ec, cyc, nd, idle_cnt;
        int dc[3];
        z = int'($urandom_range(2 * A90)) - A90;
        es = ref_val(z, 2'b11, 1'b1);
        ec = ref_val(z, 2'b01, 1'b0);
        bus.start = 1'b1;
        bus.z_in = z;
        bus.sinal_seno = 2'b11;
        bus.sinal_cosseno = 2'b01;
        nd = 0;
        idle_cnt = 0;
        for (cyc = 1; cyc <= 80 && nd < 3; cyc++) begin
            tick();
            if (nd >= 1 && !bus.busy) idle_cnt++;
            if (bus.done) begin
                dc[nd] = cyc;
                nd++;
                n_checks++;
                if (!near(bus.seno, es) || !near(bus.cosseno, ec)) begin
                    n_fail++;
                    $display("FAIL b2b_result got %0d/%0d want %0d/%0d",
                             bus.seno, bus.cosseno, es, ec);
                end
                if (nd == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (nd !== 3) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 3", nd);
        end else begin
            n_checks++;
            if (dc[0] !== LAT || dc[1] - dc[0] !== LAT || dc[2] - dc[1] !== LAT) begin
                n_fail++;
                $display("FAIL b2b_spacing got %0d,%0d,%0d want %0d each",
                         dc[0], dc[1] - dc[0], dc[2] - dc[1], LAT);
            end
            // cycles after the first done: the second and third done cycles
            n_checks++;
            if (idle_cnt !== 2) begin
                n_fail++;
                $display("FAIL b2b_idle got %0d want 2", idle_cnt);
            end
        end
        for (int k = 0; k < LAT + 2; k++) tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop got busy %b want 0", bus.busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        last_es = 0;
        last_ec = 0;
        test_reset();
        test_known_angles();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
